// File: rtl/axis_loopback_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_loopback_fifo : AXI4-Stream loopback FIFO, optional packet mode |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axis_loopback_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    keep_err
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [c_AW:0] c_ONE  = {{c_AW{1'b0}}, 1'b1};
  localparam logic [c_AW:0] c_FULL = {1'b1, {c_AW{1'b0}}};

  logic [c_EW-1:0] mem_q [DEPTH];
  logic [c_AW:0]   wr_ptr_q;
  logic [c_AW:0]   rd_ptr_q;
  logic [c_AW:0]   occ_q;
  logic [c_AW:0]   occ_d;
  logic [c_AW:0]   pkt_q;
  logic [c_AW:0]   pkt_d;
  logic            keep_err_q;

  logic            full;
  logic            push;
  logic            pop;
  logic            push_last;
  logic            pop_last;
  logic            bad_keep;
  logic            out_valid;
  logic [c_EW-1:0] head;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign full          = (occ_q == c_FULL);
  assign s_axis_tready = axi_resetn & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = out_valid & m_axis_tready;
  assign push_last     = push & s_axis_tlast;
  assign pop_last      = pop & m_axis_tlast;

  assign head          = mem_q[rd_ptr_q[c_AW-1:0]];
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head;
  assign m_axis_tvalid = out_valid;

  assign bad_keep  = (s_axis_tkeep == '0) | (~s_axis_tlast & (s_axis_tkeep != '1));
  assign occupancy = occ_q;
  assign pkt_count = pkt_q;
  assign keep_err  = keep_err_q;

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + c_ONE;
    end else if (!push && pop) begin
      occ_d = occ_q - c_ONE;
    end
  end

  always_comb begin
    pkt_d = pkt_q;
    if (push_last && !pop_last) begin
      pkt_d = pkt_q + c_ONE;
    end else if (!push_last && pop_last) begin
      pkt_d = pkt_q - c_ONE;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pkt_q      <= '0;
      keep_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + c_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + c_ONE;
      end
      occ_q <= occ_d;
      pkt_q <= pkt_d;
      if (push && bad_keep) begin
        keep_err_q <= 1'b1;
      end
    end
  end

  generate
    if (PACKET_MODE != 0) begin : g_pkt
      typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_SEND = 1'b1
      } state_t;

      state_t state_q;

      // A full FIFO releases output even without tlast so oversize packets cannot deadlock.
      always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
          state_q <= ST_HOLD;
        end else begin
          case (state_q)
            ST_HOLD: if ((pkt_q != '0) || full) state_q <= ST_SEND;
            ST_SEND: if (pop_last) state_q <= ST_HOLD;
            default: state_q <= ST_HOLD;
          endcase
        end
      end

      assign out_valid = (state_q == ST_SEND) && (occ_q != '0);
    end else begin : g_cut
      assign out_valid = (occ_q != '0);
    end
  endgenerate

endmodule
`default_nettype wire
